es_mem_req: RTL and testbench

- EXE-stage memory-request unit; sits directly upstream of the MEM stage.
- Owns the EXE valid/handshake, issues data-SRAM requests (req/addr_ok protocol) and detects address-misalignment exceptions (ALE).
- Generates store byte-enables, aligned write data and the load-type/wait-data_ok fields carried to MEM.
- Tracks outstanding requests so that data_ok beats belonging to flushed instructions are discarded.

---
 rtl/es_mem_req_pkg.sv | 37 +++
 rtl/es_mem_req_if.sv | 23 ++
 rtl/es_mem_req_st_align.sv | 41 ++++
 rtl/es_mem_req.sv | 147 ++++++++++++++
 tb/tb_es_mem_req.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/es_mem_req_pkg.sv
// Shared definitions for the EXE-stage memory-request unit: mem_op bit
// positions, SRAM size encodings, FSM state type and the alignment rule.
package es_mem_req_pkg;

  // Bit positions inside the 8-bit mem_op vector
  // {ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w}.
  localparam int OP_LD_B  = 7;
  localparam int OP_LD_BU = 6;
  localparam int OP_LD_H  = 5;
  localparam int OP_LD_HU = 4;
  localparam int OP_LD_W  = 3;
  localparam int OP_ST_B  = 2;
  localparam int OP_ST_H  = 1;
  localparam int OP_ST_W  = 0;

  // data_sram_size encodings.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // IDLE: no request accepted for the current instruction yet.
  // SENT: request accepted, instruction waiting for MEM to take it.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SENT = 1'b1
  } es_state_e;

  // Halfwords must be 2-byte aligned, words 4-byte aligned.
  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] lo);
    logic half_op;
    logic word_op;
    half_op = op[OP_LD_H] | op[OP_LD_HU] | op[OP_ST_H];
    word_op = op[OP_LD_W] | op[OP_ST_W];
    return (half_op & lo[0]) | (word_op & (lo != 2'b00));
  endfunction

endpackage

// File: rtl/es_mem_req_if.sv
// Data-SRAM request/response bus. The request fields are held stable while
// req=1 and addr_ok=0; a request is accepted in the cycle req&addr_ok=1.
// data_ok marks one response beat, in request order.
interface es_mem_req_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok
  );
endinterface

// File: rtl/es_mem_req_st_align.sv
// Combinational size / byte-enable / store-data lane replication generator.
module es_mem_req_st_align
  import es_mem_req_pkg::*;
(
  input  logic [7:0]  mem_op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [1:0]  size_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o
);

  logic byte_op;
  logic half_op;
  logic word_op;

  assign byte_op = mem_op_i[OP_LD_B] | mem_op_i[OP_LD_BU] | mem_op_i[OP_ST_B];
  assign half_op = mem_op_i[OP_LD_H] | mem_op_i[OP_LD_HU] | mem_op_i[OP_ST_H];
  assign word_op = mem_op_i[OP_LD_W] | mem_op_i[OP_ST_W];

  // Pick access size, then byte lanes and replicated data for stores only.
  always_comb begin
    size_o  = SIZE_B;
    wstrb_o = 4'b0000;
    wdata_o = st_data_i;
    if (half_op) size_o = SIZE_H;
    if (word_op) size_o = SIZE_W;
    if (byte_op) size_o = SIZE_B;
    if (mem_op_i[OP_ST_B]) begin
      wstrb_o = 4'b0001 << addr_lo_i;
      wdata_o = {4{st_data_i[7:0]}};
    end else if (mem_op_i[OP_ST_H]) begin
      wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      wdata_o = {2{st_data_i[15:0]}};
    end else if (mem_op_i[OP_ST_W]) begin
      wstrb_o = 4'b1111;
      wdata_o = st_data_i;
    end
  end

endmodule

// File: rtl/es_mem_req.sv
// EXE-stage memory-request unit: EXE valid/handshake, single data-SRAM
// request per memory instruction, ALE detection and tracking of in-flight
// requests so responses belonging to flushed instructions are dropped.
module es_mem_req
  import es_mem_req_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 2,
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ds2es_valid_i,
  output logic            es_allowin_o,
  input  logic [7:0]      ds_mem_op_i,
  input  logic            ds_ex_i,
  input  logic [31:0]     es_addr_i,
  input  logic [31:0]     es_st_data_i,
  input  logic            ms_allowin_i,
  output logic            es2ms_valid_o,
  input  logic            ms_ex_i,
  input  logic            wb_ex_i,
  es_mem_req_if.master    dsram,
  output logic            es_ale_o,
  output logic [4:0]      es_ld_inst_zip_o,
  output logic            es_wait_data_ok_o,
  output logic            data_ok_discard_o,
  output es_state_e       dbg_state_o,
  output logic [CW-1:0]   dbg_outstanding_o,
  output logic [CW-1:0]   dbg_discard_cnt_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic          es_valid_q;
  logic [7:0]    mem_op_q;
  logic          ds_ex_q;
  es_state_e     state_q;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_cnt_q, discard_cnt_d;

  logic          is_mem;
  logic          es_ale;
  logic          need_req;
  logic          req;
  logic          accept;
  logic          dec;
  logic          discard;
  logic          es_ready_go;
  logic          es_allowin;
  logic [1:0]    al_size;
  logic [3:0]    al_wstrb;
  logic [31:0]   al_wdata;

  assign is_mem   = |mem_op_q;
  assign es_ale   = es_valid_q & is_mem & misaligned(mem_op_q, es_addr_i[1:0]);
  assign need_req = es_valid_q & is_mem & ~es_ale & ~ds_ex_q & ~ms_ex_i & ~wb_ex_i;
  // Requests wait for stale responses to drain and for a free tracking slot.
  assign req      = (state_q == ST_IDLE) & need_req & (discard_cnt_q == '0)
                  & (outstanding_q < MAX_CNT);
  assign accept   = req & dsram.addr_ok;
  assign dec      = dsram.data_ok & (outstanding_q != '0);
  assign discard  = dsram.data_ok & (discard_cnt_q != '0);

  assign es_ready_go = ~need_req | accept | (state_q == ST_SENT);
  assign es_allowin  = ~es_valid_q | (es_ready_go & ms_allowin_i);

  es_mem_req_st_align u_st_align (
    .mem_op_i  (mem_op_q),
    .addr_lo_i (es_addr_i[1:0]),
    .st_data_i (es_st_data_i),
    .size_o    (al_size),
    .wstrb_o   (al_wstrb),
    .wdata_o   (al_wdata)
  );

  assign dsram.req   = req;
  assign dsram.wr    = es_valid_q & (mem_op_q[OP_ST_B] | mem_op_q[OP_ST_H] | mem_op_q[OP_ST_W]);
  assign dsram.size  = es_valid_q ? al_size  : 2'b00;
  assign dsram.wstrb = es_valid_q ? al_wstrb : 4'b0000;
  assign dsram.addr  = es_addr_i;
  assign dsram.wdata = al_wdata;

  assign es_allowin_o      = es_allowin;
  assign es2ms_valid_o     = es_valid_q & es_ready_go;
  assign es_ale_o          = es_ale;
  assign es_ld_inst_zip_o  = es_valid_q ? mem_op_q[7:3] : 5'b00000;
  assign es_wait_data_ok_o = accept | (state_q == ST_SENT);
  assign data_ok_discard_o = discard;
  assign dbg_state_o       = state_q;
  assign dbg_outstanding_o = outstanding_q;
  assign dbg_discard_cnt_o = discard_cnt_q;

  // Next values of the in-flight and to-be-discarded response counters.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !dec && outstanding_q != MAX_CNT) outstanding_d = outstanding_q + CW'(1);
    else if (!accept && dec)                        outstanding_d = outstanding_q - CW'(1);
    discard_cnt_d = discard_cnt_q;
    if (wb_ex_i)      discard_cnt_d = outstanding_q - CW'(dec);
    else if (discard) discard_cnt_d = discard_cnt_q - CW'(1);
  end

  // EXE valid bit and captured instruction fields.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      es_valid_q <= 1'b0;
      mem_op_q   <= 8'h00;
      ds_ex_q    <= 1'b0;
    end else begin
      if (wb_ex_i)         es_valid_q <= 1'b0;
      else if (es_allowin) es_valid_q <= ds2es_valid_i;
      if (ds2es_valid_i && es_allowin) begin
        mem_op_q <= ds_mem_op_i;
        ds_ex_q  <= ds_ex_i;
      end
    end
  end

  // Request FSM: remember acceptance until the instruction moves to MEM.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept && !ms_allowin_i)  state_q <= ST_SENT;
        ST_SENT: if (ms_allowin_i || wb_ex_i)  state_q <= ST_IDLE;
        default:                               state_q <= ST_IDLE;
      endcase
    end
  end

  // Response tracking counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      outstanding_q <= '0;
      discard_cnt_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  a_no_spurious_data_ok: assert property (@(posedge clk) disable iff (!resetn)
    !(dsram.data_ok && outstanding_q == '0))
    else $error("data_ok with no outstanding request");

endmodule

// File: tb/tb_es_mem_req.sv
// Directed bench for es_mem_req: a scoreboard of expected EXE->MEM handoff
// records and expected data_ok discard flags, popped by monitors.
module tb_es_mem_req;
  import es_mem_req_pkg::*;

  localparam int W = 78;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        ds2es_valid;
  logic        es_allowin;
  logic [7:0]  ds_mem_op;
  logic        ds_ex;
  logic [31:0] es_addr;
  logic [31:0] es_st_data;
  logic        ms_allowin;
  logic        es2ms_valid;
  logic        ms_ex;
  logic        wb_ex;
  logic        es_ale;
  logic [4:0]  es_ld_inst_zip;
  logic        es_wait_data_ok;
  logic        data_ok_discard;
  es_state_e   dbg_state;
  logic [1:0]  dbg_outstanding;
  logic [1:0]  dbg_discard_cnt;

  es_mem_req_if dsram ();

  es_mem_req dut (
    .clk               (clk),
    .resetn            (resetn),
    .ds2es_valid_i     (ds2es_valid),
    .es_allowin_o      (es_allowin),
    .ds_mem_op_i       (ds_mem_op),
    .ds_ex_i           (ds_ex),
    .es_addr_i         (es_addr),
    .es_st_data_i      (es_st_data),
    .ms_allowin_i      (ms_allowin),
    .es2ms_valid_o     (es2ms_valid),
    .ms_ex_i           (ms_ex),
    .wb_ex_i           (wb_ex),
    .dsram             (dsram),
    .es_ale_o          (es_ale),
    .es_ld_inst_zip_o  (es_ld_inst_zip),
    .es_wait_data_ok_o (es_wait_data_ok),
    .data_ok_discard_o (data_ok_discard),
    .dbg_state_o       (dbg_state),
    .dbg_outstanding_o (dbg_outstanding),
    .dbg_discard_cnt_o (dbg_discard_cnt)
  );

  localparam logic [7:0] LD_B = 8'b1000_0000;
  localparam logic [7:0] LD_H = 8'b0010_0000;
  localparam logic [7:0] LD_W = 8'b0000_1000;
  localparam logic [7:0] ST_B = 8'b0000_0100;
  localparam logic [7:0] ST_H = 8'b0000_0010;
  localparam logic [7:0] ST_W = 8'b0000_0001;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [0:0]   disc_q[$];
  logic [W-1:0] mon_act;
  logic [W-1:0] mon_exp;
  logic [0:0]   mon_disc;

  function automatic logic [W-1:0] rec(input logic ale, input logic wt, input logic [4:0] zip,
                                       input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                                       input logic [31:0] addr, input logic [31:0] wdata);
    return {ale, wt, zip, wr, size, wstrb, addr, wdata};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Handoff monitor: every instruction MEM takes is compared with the next record.
  always @(negedge clk) begin
    if (resetn && es2ms_valid && ms_allowin) begin
      mon_act = rec(es_ale, es_wait_data_ok, es_ld_inst_zip, dsram.wr, dsram.size,
                    dsram.wstrb, dsram.addr, dsram.wdata);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL handoff: got unexpected record %h, expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL handoff: got %h expected %h", mon_act, mon_exp);
        end
      end
    end
    if (resetn && dsram.data_ok) begin
      checks++;
      if (disc_q.size() == 0) begin
        errors++;
        $display("FAIL discard: got beat with discard=%0b, expected no beat", data_ok_discard);
      end else begin
        mon_disc = disc_q.pop_front();
        if (data_ok_discard !== mon_disc[0]) begin
          errors++;
          $display("FAIL discard: got %0b expected %0b", data_ok_discard, mon_disc[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction from ID; returns in its first EXE cycle (+1 ns).
  task automatic issue(input logic [7:0] op, input logic ex, input logic [31:0] addr,
                       input logic [31:0] data);
    tick();
    ds2es_valid = 1'b1;
    ds_mem_op   = op;
    ds_ex       = ex;
    es_addr     = addr;
    es_st_data  = data;
    tick();
    ds2es_valid = 1'b0;
  endtask

  task automatic beat(input logic exp_disc);
    tick();
    dsram.data_ok = 1'b1;
    disc_q.push_back(exp_disc);
    tick();
    dsram.data_ok = 1'b0;
  endtask

  // Memory instruction accepted immediately and taken by MEM, then answered.
  task automatic run_acc(input string name, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [W-1:0] exp);
    issue(op, 1'b0, addr, data);
    dsram.addr_ok = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    check({name, "_req"}, 32'(dsram.req), 1);
    check({name, "_es2ms"}, 32'(es2ms_valid), 1);
    tick();
    dsram.addr_ok = 1'b0;
    beat(1'b0);
  endtask

  // Instruction that must pass without a request.
  task automatic run_noreq(input string name, input logic [7:0] op, input logic ex,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [W-1:0] exp);
    issue(op, ex, addr, data);
    dsram.addr_ok = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    check({name, "_req"}, 32'(dsram.req), 0);
    check({name, "_es2ms"}, 32'(es2ms_valid), 1);
    tick();
    dsram.addr_ok = 1'b0;
    ms_ex = 1'b0;
    @(negedge clk);
    check({name, "_outstanding"}, 32'(dbg_outstanding), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    ds2es_valid   = 1'b0;
    ds_mem_op     = 8'h00;
    ds_ex         = 1'b0;
    es_addr       = 32'h0;
    es_st_data    = 32'h0;
    ms_allowin    = 1'b1;
    ms_ex         = 1'b0;
    wb_ex         = 1'b0;
    dsram.addr_ok = 1'b0;
    dsram.data_ok = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_allowin", 32'(es_allowin), 1);
    check("rst_es2ms", 32'(es2ms_valid), 0);
    check("rst_req", 32'(dsram.req), 0);
    check("rst_wr", 32'(dsram.wr), 0);
    check("rst_wstrb", 32'(dsram.wstrb), 0);
    check("rst_ale", 32'(es_ale), 0);
    check("rst_zip", 32'(es_ld_inst_zip), 0);
    check("rst_wait", 32'(es_wait_data_ok), 0);
    check("rst_discard", 32'(data_ok_discard), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_outstanding", 32'(dbg_outstanding), 0);
    check("rst_discard_cnt", 32'(dbg_discard_cnt), 0);
    tick();
    resetn = 1'b1;

    // st_b at 0x1003, immediate acceptance, leaves in the same cycle.
    issue(ST_B, 1'b0, 32'h1003, 32'h0000_00AB);
    dsram.addr_ok = 1'b1;
    exp_q.push_back(rec(1'b0, 1'b1, 5'b00000, 1'b1, SIZE_B, 4'b1000, 32'h1003, 32'hABAB_ABAB));
    @(negedge clk);
    check("stb_req", 32'(dsram.req), 1);
    check("stb_es2ms", 32'(es2ms_valid), 1);
    tick();
    dsram.addr_ok = 1'b0;
    @(negedge clk);
    check("stb_outstanding", 32'(dbg_outstanding), 1);
    check("stb_state", 32'(dbg_state), 32'(ST_IDLE));
    beat(1'b0);
    @(negedge clk);
    check("stb_drained", 32'(dbg_outstanding), 0);

    // ld_w at 0x2000, addr_ok withheld for three cycles.
    issue(LD_W, 1'b0, 32'h2000, 32'h0);
    exp_q.push_back(rec(1'b0, 1'b1, 5'b00001, 1'b0, SIZE_W, 4'b0000, 32'h2000, 32'h0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ldw_hold_req", 32'(dsram.req), 1);
      check("ldw_hold_addr", dsram.addr, 32'h2000);
      check("ldw_hold_size", 32'(dsram.size), 32'(SIZE_W));
      check("ldw_hold_es2ms", 32'(es2ms_valid), 0);
      check("ldw_hold_wait", 32'(es_wait_data_ok), 0);
      tick();
    end
    dsram.addr_ok = 1'b1;
    @(negedge clk);
    check("ldw_acc_req", 32'(dsram.req), 1);
    check("ldw_acc_wait", 32'(es_wait_data_ok), 1);
    check("ldw_acc_es2ms", 32'(es2ms_valid), 1);
    tick();
    dsram.addr_ok = 1'b0;
    beat(1'b0);

    // Misaligned ld_h: ALE, no request, passes at once.
    issue(LD_H, 1'b0, 32'h2001, 32'h0);
    exp_q.push_back(rec(1'b1, 1'b0, 5'b00100, 1'b0, SIZE_H, 4'b0000, 32'h2001, 32'h0));
    @(negedge clk);
    check("ale_flag", 32'(es_ale), 1);
    check("ale_req", 32'(dsram.req), 0);
    check("ale_es2ms", 32'(es2ms_valid), 1);
    tick();
    @(negedge clk);
    check("ale_outstanding", 32'(dbg_outstanding), 0);

    // ld_w accepted while MEM is stalled for two cycles.
    issue(LD_W, 1'b0, 32'h3000, 32'h0);
    dsram.addr_ok = 1'b1;
    ms_allowin = 1'b0;
    exp_q.push_back(rec(1'b0, 1'b1, 5'b00001, 1'b0, SIZE_W, 4'b0000, 32'h3000, 32'h0));
    @(negedge clk);
    check("stall_c1_req", 32'(dsram.req), 1);
    tick();
    @(negedge clk);
    check("stall_c2_state", 32'(dbg_state), 32'(ST_SENT));
    check("stall_c2_req", 32'(dsram.req), 0);
    check("stall_c2_wait", 32'(es_wait_data_ok), 1);
    check("stall_c2_es2ms", 32'(es2ms_valid), 1);
    tick();
    ms_allowin = 1'b1;
    @(negedge clk);
    check("stall_c3_req", 32'(dsram.req), 0);
    tick();
    dsram.addr_ok = 1'b0;
    @(negedge clk);
    check("stall_c4_state", 32'(dbg_state), 32'(ST_IDLE));
    check("stall_single_acc", 32'(dbg_outstanding), 1);
    beat(1'b0);

    // Two loads in flight, then a flush with no response in that cycle.
    issue(LD_W, 1'b0, 32'h4000, 32'h0);
    dsram.addr_ok = 1'b1;
    exp_q.push_back(rec(1'b0, 1'b1, 5'b00001, 1'b0, SIZE_W, 4'b0000, 32'h4000, 32'h0));
    tick();
    issue(LD_W, 1'b0, 32'h4004, 32'h0);
    exp_q.push_back(rec(1'b0, 1'b1, 5'b00001, 1'b0, SIZE_W, 4'b0000, 32'h4004, 32'h0));
    @(negedge clk);
    check("two_second_req", 32'(dsram.req), 1);
    tick();
    dsram.addr_ok = 1'b0;
    @(negedge clk);
    check("two_outstanding", 32'(dbg_outstanding), 2);
    tick();
    wb_ex = 1'b1;
    tick();
    wb_ex = 1'b0;
    @(negedge clk);
    check("flush_discard_cnt", 32'(dbg_discard_cnt), 2);
    issue(LD_W, 1'b0, 32'h4008, 32'h0);
    dsram.addr_ok = 1'b1;
    exp_q.push_back(rec(1'b0, 1'b1, 5'b00001, 1'b0, SIZE_W, 4'b0000, 32'h4008, 32'h0));
    @(negedge clk);
    check("blocked_req0", 32'(dsram.req), 0);
    check("blocked_es2ms0", 32'(es2ms_valid), 0);
    beat(1'b1);
    @(negedge clk);
    check("blocked_req1", 32'(dsram.req), 0);
    check("blocked_discard_cnt1", 32'(dbg_discard_cnt), 1);
    beat(1'b1);
    @(negedge clk);
    check("unblocked_req", 32'(dsram.req), 1);
    check("unblocked_es2ms", 32'(es2ms_valid), 1);
    tick();
    dsram.addr_ok = 1'b0;
    beat(1'b0);

    // Flush in the same cycle as the only outstanding response.
    issue(LD_W, 1'b0, 32'h5000, 32'h0);
    dsram.addr_ok = 1'b1;
    exp_q.push_back(rec(1'b0, 1'b1, 5'b00001, 1'b0, SIZE_W, 4'b0000, 32'h5000, 32'h0));
    tick();
    dsram.addr_ok = 1'b0;
    @(negedge clk);
    check("same_outstanding", 32'(dbg_outstanding), 1);
    tick();
    wb_ex = 1'b1;
    dsram.data_ok = 1'b1;
    disc_q.push_back(1'b0);
    tick();
    wb_ex = 1'b0;
    dsram.data_ok = 1'b0;
    @(negedge clk);
    check("same_discard_cnt", 32'(dbg_discard_cnt), 0);
    check("same_drained", 32'(dbg_outstanding), 0);
    run_acc("after_flush_ldb", LD_B, 32'h5003, 32'h0,
            rec(1'b0, 1'b1, 5'b10000, 1'b0, SIZE_B, 4'b0000, 32'h5003, 32'h0));

    // Store alignment table.
    run_acc("sth_hi", ST_H, 32'h6002, 32'h1234_ABCD,
            rec(1'b0, 1'b1, 5'b00000, 1'b1, SIZE_H, 4'b1100, 32'h6002, 32'hABCD_ABCD));
    run_acc("sth_lo", ST_H, 32'h6000, 32'h1234_5678,
            rec(1'b0, 1'b1, 5'b00000, 1'b1, SIZE_H, 4'b0011, 32'h6000, 32'h5678_5678));
    run_acc("stw", ST_W, 32'h6004, 32'hDEAD_BEEF,
            rec(1'b0, 1'b1, 5'b00000, 1'b1, SIZE_W, 4'b1111, 32'h6004, 32'hDEAD_BEEF));
    run_acc("stb_lane1", ST_B, 32'h7001, 32'h0000_005A,
            rec(1'b0, 1'b1, 5'b00000, 1'b1, SIZE_B, 4'b0010, 32'h7001, 32'h5A5A_5A5A));

    // Instructions that must not request.
    run_noreq("ds_ex", ST_W, 1'b1, 32'h8000, 32'h1122_3344,
              rec(1'b0, 1'b0, 5'b00000, 1'b1, SIZE_W, 4'b1111, 32'h8000, 32'h1122_3344));
    run_noreq("stw_ale", ST_W, 1'b0, 32'hA002, 32'h0BAD_F00D,
              rec(1'b1, 1'b0, 5'b00000, 1'b1, SIZE_W, 4'b1111, 32'hA002, 32'h0BAD_F00D));
    ms_ex = 1'b1;
    run_noreq("ms_ex", LD_W, 1'b0, 32'h9000, 32'h0,
              rec(1'b0, 1'b0, 5'b00001, 1'b0, SIZE_W, 4'b0000, 32'h9000, 32'h0));

    repeat (3) tick();
    check("exp_q_empty", 32'(exp_q.size()), 0);
    check("disc_q_empty", 32'(disc_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
